// File: rtl/breakout_brick_field.sv
// Breakout brick wall: per-brick alive state, pixel rendering and a valid/ready collision lookup.
// Optional BRICK_HP2_EN gives row-0 bricks two hit points (first hit darkens the brick).
module breakout_brick_field #(
  parameter int unsigned BLOCK_W = 40,
  parameter int unsigned BLOCK_H = 20,
  parameter int unsigned GAP     = 5,
  parameter int unsigned COLS    = 10,
  parameter int unsigned ROWS    = 4,
  parameter int unsigned START_X = 50,
  parameter int unsigned START_Y = 30
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [9:0]                        hCount,
  input  logic [9:0]                        vCount,
  output logic                              block_on,
  output logic [11:0]                       color,
  input  logic                              hit_valid,
  input  logic [9:0]                        hit_x,
  input  logic [9:0]                        hit_y,
  output logic                              hit_ready,
  output logic                              hit_done,
  output logic                              hit_brick,
  output logic                              hit_kill,
  input  logic                              field_refill,
  output logic [$clog2(COLS*ROWS+1)-1:0]    blocks_left,
  output logic [15:0]                       score,
  output logic                              all_clear
);

  localparam int unsigned PITCH_X     = BLOCK_W + GAP;
  localparam int unsigned PITCH_Y     = BLOCK_H + GAP;
  localparam int unsigned FIELD_X_END = START_X + COLS * PITCH_X - GAP;
  localparam int unsigned FIELD_Y_END = START_Y + ROWS * PITCH_Y - GAP;
  localparam int unsigned NBRICK      = COLS * ROWS;
  localparam int unsigned BL_W        = $clog2(NBRICK + 1);
  localparam int unsigned SCAN_N      = (COLS > ROWS) ? COLS : ROWS;
  localparam int unsigned CNT_W       = $clog2(SCAN_N + 1);
  localparam int unsigned COL_W       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [NBRICK-1:0] alive;
  logic [9:0]        dx;
  logic [9:0]        dy;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [CNT_W-1:0]  scan_cnt;
  logic              in_field;

  logic              accept_c;
  logic              scan_last_c;
  logic              on_brick_c;
  logic              sel_alive_c;
  logic              do_hit_c;
  logic              do_kill_c;
  logic [16:0]       score_sum_c;
  logic [COLS-1:0]   pcol_c;
  logic [ROWS-1:0]   prow_c;
  logic              pix_on_c;
  logic [11:0]       pix_color_c;

`ifdef BRICK_HP2_EN
  logic [COLS-1:0]   hp_extra;
  logic              sel_extra_c;
`endif

  function automatic logic [11:0] row_color(input logic [1:0] rm);
    case (rm)
      2'd0:    row_color = 12'hF00;
      2'd1:    row_color = 12'h0F0;
      2'd2:    row_color = 12'h00F;
      default: row_color = 12'hFF0;
    endcase
  endfunction

  // Column/row windows of the current pixel, resolved by range comparison.
  always_comb begin
    pcol_c = '0;
    prow_c = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      pcol_c[c] = (32'(hCount) >= START_X + c * PITCH_X) &&
                  (32'(hCount) <  START_X + c * PITCH_X + BLOCK_W);
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      prow_c[r] = (32'(vCount) >= START_Y + r * PITCH_Y) &&
                  (32'(vCount) <  START_Y + r * PITCH_Y + BLOCK_H);
    end
  end

  always_comb begin
    pix_on_c    = 1'b0;
    pix_color_c = 12'h000;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (prow_c[r] && pcol_c[c] && alive[r * COLS + c]) begin
          pix_on_c    = 1'b1;
          pix_color_c = row_color(2'(r));
`ifdef BRICK_HP2_EN
          if (r == 0 && !hp_extra[c]) pix_color_c = 12'h800;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      block_on <= 1'b0;
      color    <= 12'h000;
    end else begin
      block_on <= pix_on_c;
      color    <= pix_color_c;
    end
  end

  assign hit_ready   = (state == S_IDLE) && !reset && !field_refill;
  assign accept_c    = hit_valid && hit_ready;
  assign scan_last_c = (scan_cnt == CNT_W'(SCAN_N - 1));
  assign all_clear   = (blocks_left == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (accept_c) next_state = S_SCAN;
      S_SCAN:   if (scan_last_c) next_state = S_UPDATE;
      S_UPDATE: next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    if (field_refill) next_state = S_IDLE;
  end

  // Query resolution by repeated pitch subtraction, one step per SCAN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dx       <= '0;
      dy       <= '0;
      col      <= '0;
      row      <= '0;
      scan_cnt <= '0;
      in_field <= 1'b0;
    end else if (accept_c) begin
      dx       <= hit_x - 10'(START_X);
      dy       <= hit_y - 10'(START_Y);
      col      <= '0;
      row      <= '0;
      scan_cnt <= '0;
      in_field <= (32'(hit_x) >= START_X) && (32'(hit_x) < FIELD_X_END) &&
                  (32'(hit_y) >= START_Y) && (32'(hit_y) < FIELD_Y_END);
    end else if (state == S_SCAN) begin
      scan_cnt <= scan_cnt + CNT_W'(1);
      if (in_field && 32'(dx) >= PITCH_X) begin
        dx  <= dx - 10'(PITCH_X);
        col <= col + COL_W'(1);
      end
      if (in_field && 32'(dy) >= PITCH_Y) begin
        dy  <= dy - 10'(PITCH_Y);
        row <= row + ROW_W'(1);
      end
    end
  end

  always_comb begin
    on_brick_c  = in_field && (32'(dx) < BLOCK_W) && (32'(dy) < BLOCK_H);
    sel_alive_c = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (ROW_W'(r) == row && COL_W'(c) == col) sel_alive_c = alive[r * COLS + c];
      end
    end
    do_hit_c = on_brick_c && sel_alive_c;
`ifdef BRICK_HP2_EN
    sel_extra_c = 1'b0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (COL_W'(c) == col && row == '0) sel_extra_c = hp_extra[c];
    end
    do_kill_c = do_hit_c && !sel_extra_c;
`else
    do_kill_c = do_hit_c;
`endif
    score_sum_c = 17'(score) + 17'(ROWS) - 17'(row);
  end

  // Brick state, live count and score.
  always_ff @(posedge clk) begin
    if (reset || field_refill) begin
      alive       <= '1;
      blocks_left <= BL_W'(NBRICK);
      score       <= 16'h0000;
`ifdef BRICK_HP2_EN
      hp_extra    <= '1;
`endif
    end else if (state == S_UPDATE) begin
      if (do_kill_c) begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          for (int unsigned c = 0; c < COLS; c++) begin
            if (ROW_W'(r) == row && COL_W'(c) == col) alive[r * COLS + c] <= 1'b0;
          end
        end
        blocks_left <= blocks_left - BL_W'(1);
        score       <= score_sum_c[16] ? 16'hFFFF : score_sum_c[15:0];
      end
`ifdef BRICK_HP2_EN
      else if (do_hit_c) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          if (COL_W'(c) == col) hp_extra[c] <= 1'b0;
        end
      end
`endif
    end
  end

  // Result flags; a refill in UPDATE drops the result without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_done  <= 1'b0;
      hit_brick <= 1'b0;
      hit_kill  <= 1'b0;
    end else begin
      hit_done <= 1'b0;
      if (!field_refill && state == S_UPDATE) begin
        hit_done  <= 1'b1;
        hit_brick <= do_hit_c;
        hit_kill  <= do_kill_c;
      end
    end
  end

endmodule

// File: tb/tb_breakout_brick_field.sv
// Directed self-checking bench for breakout_brick_field at default geometry.
module tb_breakout_brick_field;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        block_on;
  logic [11:0] color;
  logic        hit_valid;
  logic [9:0]  hit_x;
  logic [9:0]  hit_y;
  logic        hit_ready;
  logic        hit_done;
  logic        hit_brick;
  logic        hit_kill;
  logic        field_refill;
  logic [5:0]  blocks_left;
  logic [15:0] score;
  logic        all_clear;

  int n_checks = 0;
  int n_fail   = 0;

  breakout_brick_field dut (
    .clk          (clk),
    .reset        (reset),
    .hCount       (hCount),
    .vCount       (vCount),
    .block_on     (block_on),
    .color        (color),
    .hit_valid    (hit_valid),
    .hit_x        (hit_x),
    .hit_y        (hit_y),
    .hit_ready    (hit_ready),
    .hit_done     (hit_done),
    .hit_brick    (hit_brick),
    .hit_kill     (hit_kill),
    .field_refill (field_refill),
    .blocks_left  (blocks_left),
    .score        (score),
    .all_clear    (all_clear)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int x, input int y, input logic on, input logic [11:0] col, input string tag);
    hCount = 10'(x);
    vCount = 10'(y);
    tick;
    check_eq({tag, "_on"}, 32'(block_on), 32'(on));
    check_eq({tag, "_color"}, 32'(color), 32'(col));
  endtask

  // Issues one query, returns results sampled in the done cycle, then checks the pulse ends.
  task automatic query(input int x, input int y, output logic brick, output logic kill,
                       output logic [5:0] bl, output logic [15:0] sc);
    int guard;
    int lat;
    guard = 0;
    while (!hit_ready && guard < 50) begin
      tick;
      guard++;
    end
    hit_valid = 1'b1;
    hit_x     = 10'(x);
    hit_y     = 10'(y);
    tick;
    hit_valid = 1'b0;
    lat = 1;
    while (!hit_done && lat < 40) begin
      tick;
      lat++;
    end
    check_eq("query_latency", 32'(lat), 32'd12);
    brick = hit_brick;
    kill  = hit_kill;
    bl    = blocks_left;
    sc    = score;
    tick;
    check_eq("done_one_cycle", 32'(hit_done), 32'd0);
    check_eq("ready_after_done", 32'(hit_ready), 32'd1);
  endtask

  initial begin
    logic        b;
    logic        k;
    logic [5:0]  bl;
    logic [15:0] sc;
    logic        seen;

    reset = 1'b1;
    hCount = '0;
    vCount = '0;
    hit_valid = 1'b0;
    hit_x = '0;
    hit_y = '0;
    field_refill = 1'b0;
    #2;
    check_eq("ready_in_reset", 32'(hit_ready), 32'd0);
    tick;
    tick;
    check_eq("rst_block_on", 32'(block_on), 32'd0);
    check_eq("rst_color", 32'(color), 32'd0);
    check_eq("rst_hit_done", 32'(hit_done), 32'd0);
    check_eq("rst_hit_brick", 32'(hit_brick), 32'd0);
    check_eq("rst_hit_kill", 32'(hit_kill), 32'd0);
    check_eq("rst_blocks_left", 32'(blocks_left), 32'd40);
    check_eq("rst_score", 32'(score), 32'd0);
    check_eq("rst_all_clear", 32'(all_clear), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("ready_after_reset", 32'(hit_ready), 32'd1);

    pixel(60, 35, 1'b1, 12'hF00, "pix_r0");
    pixel(60, 60, 1'b1, 12'h0F0, "pix_r1");
    pixel(60, 85, 1'b1, 12'h00F, "pix_r2");
    pixel(60, 110, 1'b1, 12'hFF0, "pix_r3");
    pixel(92, 35, 1'b0, 12'h000, "pix_gap_x");
    pixel(60, 52, 1'b0, 12'h000, "pix_gap_y");
    pixel(494, 124, 1'b1, 12'hFF0, "pix_last");
    pixel(495, 124, 1'b0, 12'h000, "pix_right_edge");
    pixel(49, 35, 1'b0, 12'h000, "pix_left_edge");

`ifdef BRICK_HP2_EN
    query(60, 35, b, k, bl, sc);
    check_eq("hp2_first_brick", 32'(b), 32'd1);
    check_eq("hp2_first_kill", 32'(k), 32'd0);
    check_eq("hp2_first_left", 32'(bl), 32'd40);
    check_eq("hp2_first_score", 32'(sc), 32'd0);
    pixel(60, 35, 1'b1, 12'h800, "pix_hp2_dim");
`endif
    query(60, 35, b, k, bl, sc);
    check_eq("q1_brick", 32'(b), 32'd1);
    check_eq("q1_kill", 32'(k), 32'd1);
    check_eq("q1_left", 32'(bl), 32'd39);
    check_eq("q1_score", 32'(sc), 32'd4);
    pixel(60, 35, 1'b0, 12'h000, "pix_killed");

    query(60, 35, b, k, bl, sc);
    check_eq("q_dead_brick", 32'(b), 32'd0);
    check_eq("q_dead_kill", 32'(k), 32'd0);
    check_eq("q_dead_left", 32'(bl), 32'd39);
    query(92, 35, b, k, bl, sc);
    check_eq("q_gap_brick", 32'(b), 32'd0);
    query(600, 400, b, k, bl, sc);
    check_eq("q_out_brick", 32'(b), 32'd0);
    check_eq("q_out_score", 32'(sc), 32'd4);

    query(494, 124, b, k, bl, sc);
    check_eq("q_corner_kill", 32'(k), 32'd1);
    check_eq("q_corner_left", 32'(bl), 32'd38);
    check_eq("q_corner_score", 32'(sc), 32'd5);

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 10; c++) begin
        if (!((r == 0 && c == 0) || (r == 3 && c == 9))) begin
`ifdef BRICK_HP2_EN
          if (r == 0) query(60 + 45 * c, 35 + 25 * r, b, k, bl, sc);
`endif
          query(60 + 45 * c, 35 + 25 * r, b, k, bl, sc);
          check_eq("kill_all", 32'(k), 32'd1);
        end
      end
    end
    check_eq("clear_left", 32'(blocks_left), 32'd0);
    check_eq("clear_score", 32'(score), 32'd100);
    check_eq("clear_flag", 32'(all_clear), 32'd1);
    pixel(200, 85, 1'b0, 12'h000, "pix_all_dead");

    field_refill = 1'b1;
    tick;
    field_refill = 1'b0;
    check_eq("refill_left", 32'(blocks_left), 32'd40);
    check_eq("refill_score", 32'(score), 32'd0);
    check_eq("refill_clear", 32'(all_clear), 32'd0);
    pixel(60, 35, 1'b1, 12'hF00, "pix_refilled");

    // refill and hit_valid together: query must not be accepted
    field_refill = 1'b1;
    hit_valid    = 1'b1;
    hit_x        = 10'd60;
    hit_y        = 10'd35;
    #1;
    check_eq("ready_in_refill", 32'(hit_ready), 32'd0);
    tick;
    field_refill = 1'b0;
    hit_valid    = 1'b0;
    #1;
    check_eq("refill_beats_valid", 32'(hit_ready), 32'd1);

    // refill three cycles after acceptance aborts the query
    hit_valid = 1'b1;
    hit_x     = 10'd60;
    hit_y     = 10'd60;
    tick;
    hit_valid = 1'b0;
    tick;
    tick;
    field_refill = 1'b1;
    #1;
    check_eq("abort_ready_in_refill", 32'(hit_ready), 32'd0);
    tick;
    field_refill = 1'b0;
    #1;
    check_eq("abort_ready_after", 32'(hit_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      seen = seen | hit_done;
    end
    check_eq("abort_no_done", 32'(seen), 32'd0);
    check_eq("abort_left", 32'(blocks_left), 32'd40);

    // reset mid-query abandons it
    hit_valid = 1'b1;
    hit_x     = 10'd105;
    hit_y     = 10'd35;
    tick;
    hit_valid = 1'b0;
    tick;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      seen = seen | hit_done;
    end
    check_eq("rst_mid_no_done", 32'(seen), 32'd0);
    check_eq("rst_mid_left", 32'(blocks_left), 32'd40);
    check_eq("rst_mid_ready", 32'(hit_ready), 32'd1);
    pixel(105, 35, 1'b1, 12'hF00, "pix_rst_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/breakout_brick_field.md
# breakout_brick_field

Parametrised brick wall for the breakout game. Each brick has its own alive state, so bricks can be destroyed and the wall refilled. The block renders the wall into the pixel stream from the display controller's `hCount`/`vCount`. It also serves ball-collision lookups over a valid/ready handshake and maintains `blocks_left`, `score` and `all_clear` for the game controller.

## Interface
- `BLOCK_W`, 40: brick width in pixels.
- `BLOCK_H`, 20: brick height in pixels.
- `GAP`, 5: spacing between bricks, both axes.
- `COLS`, 10: bricks per row (1..16).
- `ROWS`, 4: brick rows (1..8).
- `START_X`, 50: left edge of the wall.
- `START_Y`, 30: top edge of the wall.
- `clk`, in, 1: system clock. Only clock in the block.
- `reset`, in, 1: synchronous, active-high reset.
- `hCount`, in, 10: current pixel x.
- `vCount`, in, 10: current pixel y.
- `block_on`, out, 1: current pixel is on a live brick (registered).
- `color`, out, 12: RGB444 pixel colour (registered).
- `hit_valid`, in, 1: collision query request.
- `hit_x`, in, 10: query x coordinate.
- `hit_y`, in, 10: query y coordinate.
- `hit_ready`, out, 1: high only in IDLE.
- `hit_done`, out, 1: one-cycle pulse when a query result is valid.
- `hit_brick`, out, 1: query landed on a live brick.
- `hit_kill`, out, 1: that brick was destroyed.
- `field_refill`, in, 1: restore all bricks and clear the score.
- `blocks_left`, out, $clog2(COLS*ROWS+1): count of live bricks.
- `score`, out, 16: accumulated points.
- `all_clear`, out, 1: high when `blocks_left == 0`.

## Operation
- Geometry:
  - pitch_x = BLOCK_W+GAP; pitch_y = BLOCK_H+GAP.
  - The field spans x in [START_X, START_X+COLS*pitch_x-GAP) and y in [START_Y, START_Y+ROWS*pitch_y-GAP).
  - A point is on brick (c,r) iff it is inside the field, (x-START_X) mod pitch_x < BLOCK_W, and (y-START_Y) mod pitch_y < BLOCK_H.
- Alive state: COLS*ROWS bits, all set after `reset` or `field_refill`.
- Pixel path:
  - `block_on`=1 iff the pixel is on brick (c,r) and that brick's alive bit is set.
  - Colour by r mod 4: 12'hF00, 12'h0F0, 12'h00F, 12'hFF0.
  - Otherwise `block_on`=0 and `color`=12'h000.
- Divide/modulo operators are not used in either path. Column/row resolution is done by comparison or by sequential subtraction.
- Hit FSM states: IDLE → SCAN → UPDATE → DONE → IDLE.
  - IDLE: `hit_ready`=1. `hit_valid` & `hit_ready` latches `hit_x`/`hit_y` and moves to SCAN.
  - SCAN: lasts exactly max(COLS,ROWS) cycles and resolves (c,r) or miss. Out-of-field and gap points are a miss.
  - UPDATE, live brick: clear its alive bit, decrement `blocks_left`, add (ROWS-r) to `score` (saturating at 16'hFFFF).
  - UPDATE, dead brick or miss: no state change.
  - DONE: `hit_done`=1 for one cycle with `hit_brick`/`hit_kill` valid; return to IDLE.
- `hit_brick`/`hit_kill` hold their value until the next DONE.
- `field_refill` is honoured in any state:
  - Restores all bricks, sets `blocks_left`=COLS*ROWS, clears `score`.
  - Aborts any query in flight with no `hit_done` pulse; FSM returns to IDLE.
  - `hit_ready`=0 in the refill cycle.
- Refill and a `hit_valid` in the same cycle: refill wins and the query is not accepted.

## Timing
- Reset values:
  - `block_on`=0, `color`=12'h000.
  - `hit_ready`=0 during the reset cycle, then 1.
  - `hit_done`=0, `hit_brick`=0, `hit_kill`=0.
  - `blocks_left`=COLS*ROWS, `score`=0, `all_clear`=0.
  - FSM in IDLE, all bricks alive.
- Pixel latency: exactly 1 cycle from `hCount`/`vCount` to `block_on`/`color`.
- A brick cleared in UPDATE is not drawn from the following cycle.
- Query latency: with acceptance at cycle T, `hit_done` is asserted at T+max(COLS,ROWS)+2. Defaults give T+12.
- `blocks_left`/`score` update on the cycle of the `hit_done` pulse.
- `all_clear` is combinational from `blocks_left`.
- Back-to-back queries: the earliest next acceptance is the cycle after DONE.
- Reset mid-query: the query is abandoned, with no `hit_done` pulse.

## Configuration
- `BRICK_HP2_EN` defined: row-0 bricks have 2 hit points.
  - First hit: `hit_brick`=1, `hit_kill`=0, brick colour becomes 12'h800, no change to `blocks_left` or `score`.
  - Second hit: behaves as a normal kill.
  - Refill restores both hit points.
- `BRICK_HP2_EN` undefined: every brick has 1 hit point, and `hit_kill` == `hit_brick` whenever `hit_done` is high.

## Test plan
- Reset, then `hCount`=60, `vCount`=35 → next cycle `block_on`=1, `color`=12'hF00. `hCount`=60, `vCount`=60 → `color`=12'h0F0. `hCount`=92, `vCount`=35 (gap) → `block_on`=0.
- Query (60,35) → `hit_done` 12 cycles after acceptance, `hit_brick`=1, `hit_kill`=1, `blocks_left` 40→39, `score`=4. Pixel (60,35) now reads `block_on`=0.
- Repeat query (60,35) → `hit_brick`=0, no count change. Query (92,35) → miss. Query (600,400) → miss.
- Destroy all 40 bricks → `all_clear`=1, `score`=100, `blocks_left`=0. Pulse `field_refill` → `blocks_left`=40, `score`=0, `all_clear`=0.
- Assert `field_refill` 3 cycles after accepting a query → no `hit_done` pulse, `hit_ready`=1 the cycle after the refill.
- With `BRICK_HP2_EN`, query (60,35) twice → first `hit_kill`=0 and pixel colour 12'h800; second `hit_kill`=1 and `blocks_left`=39.
